pll_phase_ctrl: RTL and testbench

PLL_PHASE_CTRL -- requirements
Module: pll_phase_ctrl

---
 rtl/pll_phase_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_pll_phase_ctrl.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_phase_ctrl.sv
// Phase-step sequencer for the ECP5 EHXPLLL dynamic phase port.
// Issues PHASESTEP / PHASELOADREG pulses with setup and gap timing.
module pll_phase_ctrl #(
   parameter int SETUP_CYCLES = 4,
   parameter int PULSE_CYCLES = 4,
   parameter int GAP_CYCLES   = 8,
   parameter int CNT_W        = 4
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [1:0]       req_sel,
   input  logic             req_dir,
   input  logic [CNT_W-1:0] req_steps,
   input  logic             req_load,
   input  logic             pll_locked,
   output logic [1:0]       phasesel,
   output logic             phasedir,
   output logic             phasestep,
   output logic             phaseloadreg,
   output logic             busy,
   output logic             done,
   output logic             err
);

   localparam int MAX_SP = (SETUP_CYCLES > PULSE_CYCLES)
                           ? SETUP_CYCLES : PULSE_CYCLES;
   localparam int MAX_C  = (MAX_SP > GAP_CYCLES)
                           ? MAX_SP : GAP_CYCLES;
   localparam int TW     = (MAX_C > 1) ? $clog2(MAX_C) : 1;

   localparam logic [TW-1:0] T_SETUP = TW'(SETUP_CYCLES - 1);
   localparam logic [TW-1:0] T_PULSE = TW'(PULSE_CYCLES - 1);
   localparam logic [TW-1:0] T_GAP   = TW'(GAP_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_STEP,
      S_GAP,
      S_LOAD,
      S_LGAP
   } state_t;

   state_t           state_q, state_d;
   logic [TW-1:0]    tmr_q, tmr_d;
   logic [CNT_W-1:0] rem_q, rem_d;
   logic             load_q, load_d;
   logic [1:0]       sel_q, sel_d;
   logic             dir_q, dir_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic             rdy_en_q;

   logic             accept;
   logic             tmr_zero;
   logic [TW-1:0]    tmr_dec;

   // ready is held off until the first edge after reset release
   assign req_ready = (state_q == S_IDLE) && rdy_en_q;
   assign accept    = req_valid && req_ready;
   assign tmr_zero  = (tmr_q == '0);
   assign tmr_dec   = tmr_q - 1'b1;

   // pulses are released the same cycle lock drops
   assign phasestep    = !((state_q == S_STEP) && pll_locked);
   assign phaseloadreg = !((state_q == S_LOAD) && pll_locked);
   assign phasesel     = sel_q;
   assign phasedir     = dir_q;
   assign busy         = (state_q != S_IDLE);
   assign done         = done_q;
   assign err          = err_q;

   // next-state, timer and step-count computation
   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      rem_d   = rem_q;
      load_d  = load_q;
      sel_d   = sel_q;
      dir_d   = dir_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (!pll_locked) begin
                  err_d = 1'b1;
               end else begin
                  sel_d  = req_sel;
                  dir_d  = req_dir;
                  rem_d  = req_steps;
                  load_d = req_load;
                  if (req_steps != '0) begin
                     state_d = S_SETUP;
                     tmr_d   = T_SETUP;
                  end else if (req_load) begin
                     state_d = S_LOAD;
                     tmr_d   = T_PULSE;
                  end else begin
                     done_d = 1'b1;
                  end
               end
            end
         end
         S_SETUP: begin
            if (tmr_zero) begin
               state_d = S_STEP;
               tmr_d   = T_PULSE;
            end else begin
               tmr_d = tmr_dec;
            end
         end
         S_STEP: begin
            if (tmr_zero) begin
               state_d = S_GAP;
               tmr_d   = T_GAP;
               rem_d   = rem_q - 1'b1;
            end else begin
               tmr_d = tmr_dec;
            end
         end
         S_GAP: begin
            if (tmr_zero) begin
               if (rem_q != '0) begin
                  state_d = S_STEP;
                  tmr_d   = T_PULSE;
               end else if (load_q) begin
                  state_d = S_LOAD;
                  tmr_d   = T_PULSE;
               end else begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end
            end else begin
               tmr_d = tmr_dec;
            end
         end
         S_LOAD: begin
            if (tmr_zero) begin
               state_d = S_LGAP;
               tmr_d   = T_GAP;
            end else begin
               tmr_d = tmr_dec;
            end
         end
         S_LGAP: begin
            if (tmr_zero) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end else begin
               tmr_d = tmr_dec;
            end
         end
         default: begin
            state_d = S_IDLE;
            tmr_d   = '0;
         end
      endcase
      // loss of lock aborts any active sequence
      if ((state_q != S_IDLE) && !pll_locked) begin
         state_d = S_IDLE;
         tmr_d   = '0;
         rem_d   = '0;
         done_d  = 1'b0;
         err_d   = 1'b1;
      end
   end

   // state and datapath registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= S_IDLE;
         tmr_q    <= '0;
         rem_q    <= '0;
         load_q   <= 1'b0;
         sel_q    <= 2'b00;
         dir_q    <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         rdy_en_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         tmr_q    <= tmr_d;
         rem_q    <= rem_d;
         load_q   <= load_d;
         sel_q    <= sel_d;
         dir_q    <= dir_d;
         done_q   <= done_d;
         err_q    <= err_d;
         rdy_en_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// Directed bench for pll_phase_ctrl with default timing.
// Each scenario task drives stimulus and checks inline.
module tb_pll_phase_ctrl;

   logic       clk;
   logic       rstn;
   logic       req_valid;
   logic       req_ready;
   logic [1:0] req_sel;
   logic       req_dir;
   logic [3:0] req_steps;
   logic       req_load;
   logic       pll_locked;
   logic [1:0] phasesel;
   logic       phasedir;
   logic       phasestep;
   logic       phaseloadreg;
   logic       busy;
   logic       done;
   logic       err;

   int checks = 0;
   int errors = 0;

   int w_done, w_err;
   int w_st_low, w_st_pulses, w_st_first, w_st_wmin, w_st_wmax;
   int w_ld_low, w_ld_pulses, w_ld_first, w_ld_wmin, w_ld_wmax;
   int w_nbusy, w_rdy, w_both;

   pll_phase_ctrl dut (
      .clk          (clk),
      .rstn         (rstn),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_sel      (req_sel),
      .req_dir      (req_dir),
      .req_steps    (req_steps),
      .req_load     (req_load),
      .pll_locked   (pll_locked),
      .phasesel     (phasesel),
      .phasedir     (phasedir),
      .phasestep    (phasestep),
      .phaseloadreg (phaseloadreg),
      .busy         (busy),
      .done         (done),
      .err          (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic put_req(input logic [1:0] s, input logic d,
                          input logic [3:0] n, input logic l);
      req_valid = 1'b1;
      req_sel   = s;
      req_dir   = d;
      req_steps = n;
      req_load  = l;
   endtask

   // cycle-by-cycle observation from the first cycle after acceptance
   task automatic watch(input int limit);
      int  srun, lrun;
      logic pst, pld;
      w_done = -1; w_err = -1;
      w_st_low = 0; w_st_pulses = 0; w_st_first = -1;
      w_st_wmin = 1000; w_st_wmax = 0;
      w_ld_low = 0; w_ld_pulses = 0; w_ld_first = -1;
      w_ld_wmin = 1000; w_ld_wmax = 0;
      w_nbusy = 0; w_rdy = 0; w_both = 0;
      pst = 1'b1; pld = 1'b1; srun = 0; lrun = 0;
      for (int k = 0; k < limit; k++) begin
         if (!phasestep) begin
            if (pst) begin
               w_st_pulses++;
               if (w_st_first < 0) w_st_first = k;
            end
            srun++;
            w_st_low++;
         end else if (!pst) begin
            if (srun < w_st_wmin) w_st_wmin = srun;
            if (srun > w_st_wmax) w_st_wmax = srun;
            srun = 0;
         end
         pst = phasestep;
         if (!phaseloadreg) begin
            if (pld) begin
               w_ld_pulses++;
               if (w_ld_first < 0) w_ld_first = k;
            end
            lrun++;
            w_ld_low++;
         end else if (!pld) begin
            if (lrun < w_ld_wmin) w_ld_wmin = lrun;
            if (lrun > w_ld_wmax) w_ld_wmax = lrun;
            lrun = 0;
         end
         pld = phaseloadreg;
         if (!phasestep && !phaseloadreg) w_both++;
         if (done) begin
            w_done = k;
            break;
         end
         if (err) begin
            w_err = k;
            break;
         end
         if (!busy) w_nbusy++;
         if (req_ready) w_rdy++;
         tick();
      end
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      req_valid = 1'b0; req_sel = 2'b00; req_dir = 1'b0;
      req_steps = 4'd0; req_load = 1'b0; pll_locked = 1'b1;
      #22;
      checks++;
      if ({phasesel, phasedir, phasestep, phaseloadreg,
           busy, done, err, req_ready} !== 9'b00_0_1_1_0_0_0_0) begin
         errors++;
         $display("FAIL reset_vals got=%b exp=%b",
                  {phasesel, phasedir, phasestep, phaseloadreg,
                   busy, done, err, req_ready}, 9'b000110000);
      end
      tick();
      rstn = 1'b1;
      #1;
      checks++;
      if (req_ready !== 1'b0) begin
         errors++;
         $display("FAIL ready_pre_edge got=%b exp=0", req_ready);
      end
      tick();
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL ready_post_edge got=%b exp=1", req_ready);
      end
   endtask

   task automatic test_steps();
      put_req(2'b01, 1'b1, 4'd3, 1'b0);
      tick();
      req_valid = 1'b0;
      watch(200);
      checks++;
      if (w_done !== 40 || w_err !== -1) begin
         errors++;
         $display("FAIL steps_done_at got=%0d err=%0d exp=40", w_done, w_err);
      end
      checks++;
      if (w_st_pulses !== 3 || w_st_low !== 12) begin
         errors++;
         $display("FAIL steps_pulses got=%0d/%0d exp=3/12",
                  w_st_pulses, w_st_low);
      end
      checks++;
      if (w_st_first !== 4 || w_st_wmin !== 4 || w_st_wmax !== 4) begin
         errors++;
         $display("FAIL steps_timing first=%0d w=%0d..%0d exp=4 w=4..4",
                  w_st_first, w_st_wmin, w_st_wmax);
      end
      checks++;
      if (w_ld_pulses !== 0 || w_nbusy !== 0 || w_rdy !== 0) begin
         errors++;
         $display("FAIL steps_side ld=%0d nbusy=%0d rdy=%0d exp=0/0/0",
                  w_ld_pulses, w_nbusy, w_rdy);
      end
      checks++;
      if (phasesel !== 2'b01 || phasedir !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL steps_sel got=%b%b busy=%b exp=011 busy=0",
                  phasesel, phasedir, busy);
      end
      tick();
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL steps_done_width got=%b exp=0", done);
      end
   endtask

   task automatic test_load();
      put_req(2'b10, 1'b0, 4'd0, 1'b1);
      tick();
      req_valid = 1'b0;
      watch(200);
      checks++;
      if (w_done !== 12 || w_err !== -1) begin
         errors++;
         $display("FAIL load_done_at got=%0d err=%0d exp=12", w_done, w_err);
      end
      checks++;
      if (w_st_pulses !== 0 || w_ld_pulses !== 1 || w_ld_first !== 0 ||
          w_ld_wmax !== 4 || w_ld_low !== 4) begin
         errors++;
         $display("FAIL load_pulse st=%0d ld=%0d first=%0d w=%0d low=%0d exp=0 1 0 4 4",
                  w_st_pulses, w_ld_pulses, w_ld_first, w_ld_wmax, w_ld_low);
      end
   endtask

   task automatic test_zero();
      put_req(2'b11, 1'b0, 4'd0, 1'b0);
      tick();
      req_valid = 1'b0;
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || err !== 1'b0 ||
          phasesel !== 2'b11 || phasestep !== 1'b1) begin
         errors++;
         $display("FAIL zero_done got done=%b busy=%b err=%b sel=%b exp 1 0 0 11",
                  done, busy, err, phasesel);
      end
      tick();
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL zero_done_width got=%b exp=0", done);
      end
   endtask

   task automatic test_unlocked();
      pll_locked = 1'b0;
      put_req(2'b10, 1'b1, 4'd2, 1'b1);
      tick();
      req_valid = 1'b0;
      checks++;
      if (err !== 1'b1 || done !== 1'b0 || req_ready !== 1'b1 ||
          busy !== 1'b0) begin
         errors++;
         $display("FAIL unlock_err got err=%b done=%b rdy=%b busy=%b exp 1 0 1 0",
                  err, done, req_ready, busy);
      end
      checks++;
      if (phasesel !== 2'b11 || phasedir !== 1'b0) begin
         errors++;
         $display("FAIL unlock_sel got=%b%b exp=110", phasesel, phasedir);
      end
      tick();
      checks++;
      if (err !== 1'b0 || phasestep !== 1'b1 || phaseloadreg !== 1'b1) begin
         errors++;
         $display("FAIL unlock_after got err=%b st=%b ld=%b exp 0 1 1",
                  err, phasestep, phaseloadreg);
      end
      pll_locked = 1'b1;
      tick();
   endtask

   task automatic test_abort();
      put_req(2'b10, 1'b0, 4'd5, 1'b0);
      tick();
      req_valid = 1'b0;
      for (int i = 0; i < 17; i++) tick();
      checks++;
      if (phasestep !== 1'b0) begin
         errors++;
         $display("FAIL abort_in_pulse got=%b exp=0", phasestep);
      end
      pll_locked = 1'b0;
      #1;
      checks++;
      if (phasestep !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL abort_release got st=%b busy=%b exp 1 1",
                  phasestep, busy);
      end
      tick();
      checks++;
      if (err !== 1'b1 || done !== 1'b0 || busy !== 1'b0 ||
          req_ready !== 1'b1) begin
         errors++;
         $display("FAIL abort_err got err=%b done=%b busy=%b rdy=%b exp 1 0 0 1",
                  err, done, busy, req_ready);
      end
      pll_locked = 1'b1;
      tick();
      checks++;
      if (err !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL abort_after got err=%b done=%b exp 0 0", err, done);
      end
   endtask

   task automatic test_reset_mid();
      put_req(2'b11, 1'b1, 4'd2, 1'b0);
      tick();
      req_valid = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      rstn = 1'b0;
      #1;
      checks++;
      if ({phasesel, phasedir, phasestep, phaseloadreg,
           busy, done, err, req_ready} !== 9'b00_0_1_1_0_0_0_0) begin
         errors++;
         $display("FAIL rstmid_vals got=%b exp=%b",
                  {phasesel, phasedir, phasestep, phaseloadreg,
                   busy, done, err, req_ready}, 9'b000110000);
      end
      tick();
      tick();
      rstn = 1'b1;
      tick();
      checks++;
      if (done !== 1'b0 || err !== 1'b0 || req_ready !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_release got done=%b err=%b rdy=%b exp 0 0 1",
                  done, err, req_ready);
      end
      put_req(2'b10, 1'b1, 4'd1, 1'b0);
      tick();
      req_valid = 1'b0;
      watch(200);
      checks++;
      if (w_done !== 16 || w_st_pulses !== 1 || phasesel !== 2'b10) begin
         errors++;
         $display("FAIL rstmid_newreq got done=%0d pulses=%0d sel=%b exp 16 1 10",
                  w_done, w_st_pulses, phasesel);
      end
   endtask

   task automatic test_back_to_back();
      put_req(2'b00, 1'b0, 4'd1, 1'b1);
      tick();
      put_req(2'b10, 1'b1, 4'd0, 1'b1);
      watch(200);
      checks++;
      if (w_done !== 28 || w_rdy !== 0 || w_nbusy !== 0) begin
         errors++;
         $display("FAIL b2b_first got done=%0d rdy=%0d nbusy=%0d exp 28 0 0",
                  w_done, w_rdy, w_nbusy);
      end
      checks++;
      if (w_st_pulses !== 1 || w_ld_pulses !== 1 || w_both !== 0 ||
          phasesel !== 2'b00 || req_ready !== 1'b1) begin
         errors++;
         $display("FAIL b2b_first_pulses st=%0d ld=%0d both=%0d sel=%b rdy=%b exp 1 1 0 00 1",
                  w_st_pulses, w_ld_pulses, w_both, phasesel, req_ready);
      end
      tick();
      req_valid = 1'b0;
      watch(200);
      checks++;
      if (w_done !== 12 || w_st_pulses !== 0 || w_ld_pulses !== 1 ||
          w_both !== 0) begin
         errors++;
         $display("FAIL b2b_second got done=%0d st=%0d ld=%0d both=%0d exp 12 0 1 0",
                  w_done, w_st_pulses, w_ld_pulses, w_both);
      end
      checks++;
      if (phasesel !== 2'b10 || phasedir !== 1'b1) begin
         errors++;
         $display("FAIL b2b_sel got=%b%b exp=101", phasesel, phasedir);
      end
   endtask

   initial begin
      test_reset();
      test_steps();
      test_load();
      test_zero();
      test_unlocked();
      test_abort();
      test_reset_mid();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
